// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the RegFile write port between ALU and load writebacks.
// Optional write-to-read bypass when WB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_stall,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rg_rd_addr1,
    output logic [ADDR_W-1:0] rg_rd_addr2,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [CNT_W-1:0]  wb_count
);
    logic              rr_ptr;
    logic              open;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr;

    always_comb begin
        open       = !reset && !wb_stall;
        req0_ready = open && req0_valid && (!req1_valid || !rr_ptr);
        req1_ready = open && req1_valid && (!req0_valid || rr_ptr);
        grant      = req0_ready || req1_ready;
        sel_addr   = req1_ready ? req1_addr : req0_addr;
        sel_data   = req1_ready ? req1_data : req0_data;
        wr         = grant && (sel_addr != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= 1'b0;
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
            wb_count    <= '0;
        end else begin
            if (grant)
                rr_ptr <= req0_ready;
            rg_wrt_en <= wr;
            if (wr) begin
                rg_wrt_addr <= sel_addr;
                rg_wrt_data <= sel_data;
            end
            wb_count <= wb_count + CNT_W'(wr);
        end
    end

    assign rg_rd_addr1 = rd_addr1;
    assign rg_rd_addr2 = rd_addr2;

`ifdef WB_BYPASS_EN
    assign rd_data1 = (rg_wrt_en && rg_wrt_addr == rd_addr1 && rd_addr1 != '0) ? rg_wrt_data : rf_rd_data1;
    assign rd_data2 = (rg_wrt_en && rg_wrt_addr == rd_addr2 && rd_addr2 != '0) ? rg_wrt_data : rf_rd_data2;
`else
    assign rd_data1 = rf_rd_data1;
    assign rd_data2 = rf_rd_data2;
`endif
endmodule
